wb_queue: RTL and testbench
===========================

WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, register address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-003 SHALL have parameter DEPTH, default 4, queue entries; power of 2, >=2.
REQ-004 SHALL have port clk  input  1  single clock; all state on posedge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  producer has a writeback result.
REQ-007 SHALL have port in_ready  output  1  queue can accept a result.
REQ-008 SHALL have port in_rd  input  ADDR_WIDTH  destination register.
REQ-009 SHALL have port in_data  input  DATA_WIDTH  result value.
REQ-010 SHALL have port drain_en  input  1  register file write port is available this cycle.
REQ-011 SHALL have port rf_wen  output  1  register file write enable.
REQ-012 SHALL have port rf_rd  output  ADDR_WIDTH  register file write address.
REQ-013 SHALL have port rf_busW  output  DATA_WIDTH  register file write data.
REQ-014 SHALL have ports rs1, rs2  input  ADDR_WIDTH  source registers to check for hazards.
REQ-015 SHALL have ports rs1_busy, rs2_busy  output  1  source has a pending write.
REQ-016 SHALL have ports rs1_fwd, rs2_fwd  output  DATA_WIDTH  forwarded pending value.
REQ-017 SHALL have port count  output  clog2(DEPTH)+1  occupied entries.

Function
REQ-018 SHALL be an in-order FIFO of {rd, data} entries with read/write pointers wrapping modulo DEPTH.
REQ-019 SHALL drive in_ready = (count < DEPTH); a pop in the same cycle SHALL NOT raise in_ready while full.
REQ-020 SHALL push on a posedge with in_valid && in_ready && in_rd != 0.
REQ-021 SHALL complete the handshake for in_rd == 0 but SHALL drop the entry: no enqueue, count unchanged, no rf_wen.
REQ-022 SHALL drive rf_wen = drain_en && count != 0, combinationally from the head entry; rf_rd and rf_busW SHALL equal the head rd/data.
REQ-023 SHALL pop the head on the posedge where rf_wen = 1; the register file consumes the write within that cycle.
REQ-024 Latency: a result accepted at edge N into an empty queue SHALL present rf_wen = 1 during the cycle after edge N and SHALL pop at edge N+1.
REQ-025 SHALL hold rf_rd and rf_busW at 0 when count == 0.
REQ-026 Simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-027 SHALL assert rsX_busy when rsX != 0 and any occupied entry has rd == rsX.
REQ-028 SHALL drive rsX_fwd with the data of the youngest matching occupied entry; it SHALL be 0 when rsX_busy = 0.
REQ-029 Hazard outputs SHALL be combinational over stored entries only; the entry being offered on in_* in the same cycle SHALL NOT be included.
REQ-030 Hazard outputs SHALL include the head entry during the cycle it is being written.

Reset
REQ-031 rst_n low SHALL immediately clear pointers and count, and discard all pending entries.
REQ-032 While in reset and after reset: count = 0, in_ready = 1, rf_wen = 0, rf_rd = 0, rf_busW = 0, rsX_busy = 0, rsX_fwd = 0.
REQ-033 Entry storage need not be reset; occupancy SHALL gate every output derived from it.
REQ-034 Reset mid-operation SHALL lose pending entries without issuing any further rf_wen.

Verification
REQ-035 Reset, drain_en = 1, push rd = 3, data = 0xDEADBEEF -> next cycle rf_wen = 1, rf_rd = 3, rf_busW = 0xDEADBEEF; count = 0 after the following edge.
REQ-036 drain_en = 0, push rd = 1..4 -> count = 4, in_ready = 0, a 5th in_valid held unaccepted; then drain_en = 1 -> rf_rd = 1, 2, 3, 4 on consecutive cycles, then count = 0.
REQ-037 Push rd = 0, data = 5 -> handshake completes, count stays 0, rf_wen stays 0.
REQ-038 drain_en = 0, push rd = 7/data = 1 then rd = 7/data = 2, rs1 = 7, rs2 = 0 -> rs1_busy = 1, rs1_fwd = 2, rs2_busy = 0, rs2_fwd = 0.
REQ-039 count = 2, drain_en = 1, push each cycle -> count stays 2 and output order matches input order.
REQ-040 count = 3, drop rst_n asynchronously mid-cycle -> count = 0, rf_wen = 0, rs1_busy = 0 before the next edge; no stale writes after release.

Source files
------------

// File: rtl/wb_queue.sv
// In-order writeback queue between result producers and the register file.
// Offers pending-write hazard status and forwarding of the youngest pending value.
module wb_queue #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_WIDTH-1:0]    in_rd,
    input  logic [DATA_WIDTH-1:0]    in_data,
    input  logic                     drain_en,
    output logic                     rf_wen,
    output logic [ADDR_WIDTH-1:0]    rf_rd,
    output logic [DATA_WIDTH-1:0]    rf_busW,
    input  logic [ADDR_WIDTH-1:0]    rs1,
    input  logic [ADDR_WIDTH-1:0]    rs2,
    output logic                     rs1_busy,
    output logic                     rs2_busy,
    output logic [DATA_WIDTH-1:0]    rs1_fwd,
    output logic [DATA_WIDTH-1:0]    rs2_fwd,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_WIDTH-1:0] rd_q   [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic [CW-1:0]         cnt;
    logic                  occ;
    logic                  push;
    logic                  pop;

    assign count    = cnt;
    assign occ      = (cnt != '0);
    assign in_ready = (cnt < CW'(DEPTH));
    // x0 writes complete the handshake but are never stored
    assign push     = in_valid && in_ready && (in_rd != '0);
    assign pop      = rf_wen;

    assign rf_wen  = drain_en && occ;
    assign rf_rd   = occ ? rd_q[rptr]   : '0;
    assign rf_busW = occ ? data_q[rptr] : '0;

    // Pointer and occupancy bookkeeping; reset discards all entries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (push && !pop)
                cnt <= cnt + 1'b1;
            else if (pop && !push)
                cnt <= cnt - 1'b1;
        end
    end

    // Entry storage; validity comes only from occupancy, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            rd_q[wptr]   <= in_rd;
            data_q[wptr] <= in_data;
        end
    end

    // Scan oldest to youngest so the youngest match wins
    always_comb begin
        logic [PW-1:0] idx;
        rs1_busy = 1'b0;
        rs2_busy = 1'b0;
        rs1_fwd  = '0;
        rs2_fwd  = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rptr + i[PW-1:0];
            if (CW'(i) < cnt) begin
                if (rs1 != '0 && rd_q[idx] == rs1) begin
                    rs1_busy = 1'b1;
                    rs1_fwd  = data_q[idx];
                end
                if (rs2 != '0 && rd_q[idx] == rs2) begin
                    rs2_busy = 1'b1;
                    rs2_fwd  = data_q[idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_queue.sv
// Randomized scoreboard bench for wb_queue.
// Reference model is a plain queue of {rd, data} pending writes.
module tb_wb_queue;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int DP = 4;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } ent_t;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_rd;
    logic [DW-1:0] in_data;
    logic          drain_en;
    logic          rf_wen;
    logic [AW-1:0] rf_rd;
    logic [DW-1:0] rf_busW;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          rs1_busy;
    logic          rs2_busy;
    logic [DW-1:0] rs1_fwd;
    logic [DW-1:0] rs2_fwd;
    logic [2:0]    count;

    ent_t model[$];
    int   n_cmp;
    int   n_bad;

    wb_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DP)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_data(in_data),
        .drain_en(drain_en),
        .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_busW(rf_busW),
        .rs1(rs1), .rs2(rs2),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(string name, logic [63:0] act,
                                  logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endfunction

    function automatic void hazard(input logic [AW-1:0] rs,
                                   output logic busy,
                                   output logic [DW-1:0] fwd);
        busy = 1'b0;
        fwd  = '0;
        if (rs != '0)
            foreach (model[k])
                if (model[k].rd == rs) begin
                    busy = 1'b1;
                    fwd  = model[k].data;
                end
    endfunction

    // Monitor: compare outputs mid-cycle, then advance the model
    always @(negedge clk) begin
        logic          b;
        logic [DW-1:0] f;
        ent_t          h;
        check("count", 64'(count), 64'(model.size()));
        check("in_ready", 64'(in_ready), 64'(model.size() < DP));
        check("rf_wen", 64'(rf_wen),
              64'(drain_en && model.size() != 0));
        if (model.size() == 0) begin
            check("rf_rd_idle", 64'(rf_rd), 64'd0);
            check("rf_busW_idle", 64'(rf_busW), 64'd0);
        end else if (drain_en) begin
            h = model[0];
            check("rf_rd", 64'(rf_rd), 64'(h.rd));
            check("rf_busW", 64'(rf_busW), 64'(h.data));
        end
        hazard(rs1, b, f);
        check("rs1_busy", 64'(rs1_busy), 64'(b));
        check("rs1_fwd", 64'(rs1_fwd), 64'(f));
        hazard(rs2, b, f);
        check("rs2_busy", 64'(rs2_busy), 64'(b));
        check("rs2_fwd", 64'(rs2_fwd), 64'(f));
        if (rst_n) begin
            logic acc;
            acc = in_valid && model.size() < DP && in_rd != '0;
            if (drain_en && model.size() != 0) void'(model.pop_front());
            if (acc) model.push_back('{rd: in_rd, data: in_data});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] rd,
                         input logic [DW-1:0] d, input logic de);
        in_valid = v;
        in_rd    = rd;
        in_data  = d;
        drain_en = de;
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        rs1      = '0;
        rs2      = '0;
        #1;
        check("rst_count", 64'(count), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_wen", 64'(rf_wen), 64'd0);
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // single result drains the cycle after acceptance
        drive(1'b1, 5'd3, 32'hDEADBEEF, 1'b1);
        step();
        drive(1'b0, '0, '0, 1'b1);
        check("lat_wen", 64'(rf_wen), 64'd1);
        check("lat_rd", 64'(rf_rd), 64'd3);
        check("lat_data", 64'(rf_busW), 64'hDEADBEEF);
        step();
        check("lat_empty", 64'(count), 64'd0);

        // fill to full, hold a 5th, then drain in order
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, AW'(i), DW'(32'h100 + i), 1'b0);
            step();
        end
        drive(1'b1, 5'd5, 32'h105, 1'b0);
        repeat (2) step();
        check("full_count", 64'(count), 64'd4);
        check("full_ready", 64'(in_ready), 64'd0);
        drive(1'b0, '0, '0, 1'b1);
        repeat (5) step();
        check("drained", 64'(count), 64'd0);

        // x0 destination is accepted and dropped
        drive(1'b1, 5'd0, 32'd5, 1'b1);
        step();
        drive(1'b0, '0, '0, 1'b1);
        check("x0_count", 64'(count), 64'd0);
        check("x0_wen", 64'(rf_wen), 64'd0);

        // youngest matching entry forwards
        drive(1'b1, 5'd7, 32'd1, 1'b0);
        step();
        drive(1'b1, 5'd7, 32'd2, 1'b0);
        step();
        drive(1'b1, 5'd9, 32'd3, 1'b0);
        rs1 = 5'd7;
        rs2 = 5'd0;
        #1;
        check("fwd_busy1", 64'(rs1_busy), 64'd1);
        check("fwd_val1", 64'(rs1_fwd), 64'd2);
        check("fwd_busy2", 64'(rs2_busy), 64'd0);
        rs2 = 5'd9;
        #1;
        check("fwd_offered", 64'(rs2_busy), 64'd0);

        // steady push+pop keeps count at 2
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, AW'(10 + i), DW'(32'h200 + i), 1'b1);
            step();
        end
        check("steady_count", 64'(count), 64'd2);

        // fill to 3, then asynchronous reset mid-cycle
        drive(1'b1, 5'd11, 32'h11, 1'b0);
        step();
        drive(1'b0, '0, '0, 1'b0);
        check("pre_rst_count", 64'(count), 64'd3);
        rs1 = 5'd11;
        drive(1'b0, '0, '0, 1'b1);
        #1;
        rst_n = 1'b0;
        model.delete();
        #1;
        check("arst_count", 64'(count), 64'd0);
        check("arst_wen", 64'(rf_wen), 64'd0);
        check("arst_busy", 64'(rs1_busy), 64'd0);
        step();
        rst_n = 1'b1;
        repeat (3) step();

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            drive($urandom_range(0, 3) != 0,
                  AW'($urandom_range(0, 12)),
                  DW'($urandom),
                  $urandom_range(0, 2) != 0);
            rs1 = AW'($urandom_range(0, 12));
            rs2 = AW'($urandom_range(0, 12));
            step();
        end
        drive(1'b0, '0, '0, 1'b1);
        repeat (6) step();
        check("final_empty", 64'(count), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
